sound_mixer: RTL and testbench

Downstream stage of the four tone/noise channels: takes the 4-bit outputs of square 1, square 2, wave and noise and applies NR51 panning and NR50 master volume. It produces a 9-bit left and right mix and drives one PWM output per side, which feeds the board RC filter.
Samples are latched once per PWM frame. The frame rate equals the mixer clock divided by 512.

---
 rtl/sound_mixer.sv | 144 ++++++++++++++
 tb/tb_sound_mixer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sound_mixer.sv
// sound_mixer: final mixing stage behind the four tone/noise channels.
// It masks each 4-bit channel level with its DAC enable and the master enable.
// It then pans each channel to left/right with nr51 and scales each side by
// (nr50 volume + 1). Each side's mix is latched once per PWM frame of
// 2^PWM_BITS cycles and drives a PWM bit for the board RC filter.
//
// Ports:
//   clk, rstN              mixer clock, asynchronous active-low reset
//   sq1, sq2, wave, noise  4-bit channel levels
//   chanOn[3:0]            per-channel DAC enable (bit0=sq1 .. bit3=noise)
//   nr50[7:0]              [6:4] left volume, [2:0] right volume, [7]/[3] Vin (unused)
//   nr51[7:0]              [7:4] left enables, [3:0] right enables (noise,wave,sq2,sq1)
//   apuEnable              master enable; low holds the frame counter and clears outputs
//   leftSample/rightSample latched mix, updated at each frame wrap
//   sampleStrobe           high for the cycle in which the counter is 0 after a wrap
//   leftPwm/rightPwm       registered (counter < latched sample)
module sound_mixer #(
  parameter int PWM_BITS = 9
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [3:0]          sq1,
  input  logic [3:0]          sq2,
  input  logic [3:0]          wave,
  input  logic [3:0]          noise,
  input  logic [3:0]          chanOn,
  input  logic [7:0]          nr50,
  input  logic [7:0]          nr51,
  input  logic                apuEnable,
  output logic [PWM_BITS-1:0] leftSample,
  output logic [PWM_BITS-1:0] rightSample,
  output logic                sampleStrobe,
  output logic                leftPwm,
  output logic                rightPwm
);

  // Sum of four routed 4-bit levels: 0..60.
  function automatic logic [5:0] sum4(input logic [3:0][3:0] ch);
    sum4 = 6'(ch[0]) + 6'(ch[1]) + 6'(ch[2]) + 6'(ch[3]);
  endfunction

  // sum * (vol + 1) peaks at 60 * 8 = 480, so it always fits in 9 bits and
  // needs no saturation.
  function automatic logic [PWM_BITS-1:0] scale(input logic [5:0] sum,
                                                input logic [2:0] vol);
    logic [9:0] prod;
    prod  = 10'(sum) * (10'(vol) + 10'd1);
    scale = PWM_BITS'(prod);
  endfunction

  logic [3:0][3:0]      w_ch;
  logic [3:0]           w_en;
  logic [3:0][3:0]      w_lch;
  logic [3:0][3:0]      w_rch;
  logic                 w_wrap;
  logic                 w_unused_vin;

  logic [3:0][3:0]      r_lch_p0;
  logic [3:0][3:0]      r_rch_p0;
  logic [2:0]           r_lvol_p0;
  logic [2:0]           r_rvol_p0;
  logic [5:0]           r_lsum_p1;
  logic [5:0]           r_rsum_p1;
  logic [2:0]           r_lvol_p1;
  logic [2:0]           r_rvol_p1;
  logic [PWM_BITS-1:0]  r_lmix_p2;
  logic [PWM_BITS-1:0]  r_rmix_p2;
  logic [PWM_BITS-1:0]  r_cnt;

  assign w_unused_vin = nr50[7] ^ nr50[3];
  assign w_ch   = {noise, wave, sq2, sq1};
  assign w_en   = chanOn & {4{apuEnable}};
  assign w_wrap = &r_cnt;

  always_comb begin
    w_lch = '0;
    w_rch = '0;
    for (int i = 0; i < 4; i++) begin
      w_lch[i] = (w_en[i] && nr51[4+i]) ? w_ch[i] : 4'd0;
      w_rch[i] = (w_en[i] && nr51[i])   ? w_ch[i] : 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_lch_p0  <= '0;
      r_rch_p0  <= '0;
      r_lvol_p0 <= '0;
      r_rvol_p0 <= '0;
      r_lsum_p1 <= '0;
      r_rsum_p1 <= '0;
      r_lvol_p1 <= '0;
      r_rvol_p1 <= '0;
      r_lmix_p2 <= '0;
      r_rmix_p2 <= '0;
    end else begin
      // stage p0: masked, panned channels and captured volumes
      r_lch_p0  <= w_lch;
      r_rch_p0  <= w_rch;
      r_lvol_p0 <= nr50[6:4];
      r_rvol_p0 <= nr50[2:0];
      // stage p1: per-side sums
      r_lsum_p1 <= sum4(r_lch_p0);
      r_rsum_p1 <= sum4(r_rch_p0);
      r_lvol_p1 <= r_lvol_p0;
      r_rvol_p1 <= r_rvol_p0;
      // stage p2: volume-scaled mix
      r_lmix_p2 <= scale(r_lsum_p1, r_lvol_p1);
      r_rmix_p2 <= scale(r_rsum_p1, r_rvol_p1);
    end
  end

  // Frame counter, sample latch and PWM. The disable branch comes first so
  // that a wrap coinciding with apuEnable low still clears the samples.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt        <= '0;
      leftSample   <= '0;
      rightSample  <= '0;
      sampleStrobe <= 1'b0;
      leftPwm      <= 1'b0;
      rightPwm     <= 1'b0;
    end else if (!apuEnable) begin
      r_cnt        <= '0;
      leftSample   <= '0;
      rightSample  <= '0;
      sampleStrobe <= 1'b0;
      leftPwm      <= 1'b0;
      rightPwm     <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      sampleStrobe <= w_wrap;
      if (w_wrap) begin
        leftSample  <= r_lmix_p2;
        rightSample <= r_rmix_p2;
      end
      // Compare against the sample already latched, so mid-frame changes
      // never disturb the duty of the frame in progress.
      leftPwm      <= (r_cnt < leftSample);
      rightPwm     <= (r_cnt < rightSample);
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
module tb_sound_mixer;

  localparam int PWM_BITS = 9;

  logic                clk;
  logic                rstN;
  logic [3:0]          sq1, sq2, wave, noise, chanOn;
  logic [7:0]          nr50, nr51;
  logic                apuEnable;
  logic [PWM_BITS-1:0] leftSample, rightSample;
  logic                sampleStrobe, leftPwm, rightPwm;

  sound_mixer #(.PWM_BITS(PWM_BITS)) dut (
    .clk(clk), .rstN(rstN),
    .sq1(sq1), .sq2(sq2), .wave(wave), .noise(noise),
    .chanOn(chanOn), .nr50(nr50), .nr51(nr51), .apuEnable(apuEnable),
    .leftSample(leftSample), .rightSample(rightSample),
    .sampleStrobe(sampleStrobe), .leftPwm(leftPwm), .rightPwm(rightPwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s1, s2, wv, nz, on;
    logic [7:0] v50, v51;
    int         expL, expR;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    sq1 = v.s1; sq2 = v.s2; wave = v.wv; noise = v.nz;
    chanOn = v.on; nr50 = v.v50; nr51 = v.v51;
  endtask

  // Advance to the next negedge at which sampleStrobe is high; n = posedges taken.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!sampleStrobe && n < 2000);
    if (!sampleStrobe) chk("strobe_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hl, hr, hs;
    vec_t v;

    //            s1     s2     wv     nz     on     nr50   nr51   L    R
    vecs[0] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 8'h77, 8'hFF, 480, 480};
    vecs[1] = '{4'd15, 4'd0,  4'd0,  4'd0,  4'hF, 8'h70, 8'h10, 120, 0};
    vecs[2] = '{4'd15, 4'd0,  4'd0,  4'd0,  4'hF, 8'h07, 8'h01, 0,   120};
    vecs[3] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'hF, 8'h00, 8'hFF, 60,  60};
    vecs[4] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'h5, 8'h00, 8'hFF, 30,  30};
    vecs[5] = '{4'd0,  4'd0,  4'd0,  4'd9,  4'hF, 8'h70, 8'h80, 72,  0};
    // left = wave+sq1 = 10, x4 = 40; right = noise+sq2 = 6, x6 = 36; Vin bits set
    vecs[6] = '{4'd3,  4'd5,  4'd7,  4'd1,  4'hF, 8'hBD, 8'h5A, 40,  36};

    rstN = 1'b0; apuEnable = 1'b0;
    set_in(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_leftSample", int'(leftSample), 0);
    chk("rst_rightSample", int'(rightSample), 0);
    chk("rst_strobe", int'(sampleStrobe), 0);
    chk("rst_leftPwm", int'(leftPwm), 0);
    chk("rst_rightPwm", int'(rightPwm), 0);

    rstN = 1'b1; apuEnable = 1'b1;
    wait_strobe(n);
    chk("first_strobe_cycles", n, 512);

    for (int k = 0; k < 7; k++) begin
      set_in(vecs[k]);
      wait_strobe(n);
      wait_strobe(n);
      chk($sformatf("v%0d_leftSample", k), int'(leftSample), vecs[k].expL);
      chk($sformatf("v%0d_rightSample", k), int'(rightSample), vecs[k].expR);
      hl = 0; hr = 0; hs = 0;
      for (int i = 0; i < 512; i++) begin
        hl += int'(leftPwm); hr += int'(rightPwm); hs += int'(sampleStrobe);
        @(negedge clk);
      end
      chk($sformatf("v%0d_leftPwm_high", k), hl, vecs[k].expL);
      chk($sformatf("v%0d_rightPwm_high", k), hr, vecs[k].expR);
      chk($sformatf("v%0d_strobes", k), hs, 1);
    end

    // Latency: noise 0 -> 9, routed left at volume 7.
    v = vecs[5]; v.nz = 4'd0;
    set_in(v);
    wait_strobe(n);
    wait_strobe(n);
    chk("lat_leftSample_before", int'(leftSample), 0);
    repeat (10) @(negedge clk);
    noise = 4'd9;
    @(posedge clk); @(posedge clk); #1;
    chk("lat_mix_2edges", int'(dut.r_lmix_p2), 0);
    @(posedge clk); #1;
    chk("lat_mix_3edges", int'(dut.r_lmix_p2), 72);
    chk("lat_leftSample_held", int'(leftSample), 0);
    wait_strobe(n);
    chk("lat_leftSample_after", int'(leftSample), 72);
    chk("lat_rightSample_after", int'(rightSample), 0);

    // apuEnable dropped at counter 200, then re-enabled.
    set_in(vecs[0]);
    wait_strobe(n);
    wait_strobe(n);
    repeat (200) @(negedge clk);
    chk("dis_leftPwm_before", int'(leftPwm), 1);
    apuEnable = 1'b0;
    @(negedge clk);
    chk("dis_leftPwm", int'(leftPwm), 0);
    chk("dis_rightPwm", int'(rightPwm), 0);
    chk("dis_leftSample", int'(leftSample), 0);
    chk("dis_rightSample", int'(rightSample), 0);
    hs = 0;
    for (int i = 0; i < 600; i++) begin
      hs += int'(sampleStrobe) + int'(leftPwm);
      @(negedge clk);
    end
    chk("dis_quiet", hs, 0);
    apuEnable = 1'b1;
    wait_strobe(n);
    chk("reen_strobe_cycles", n, 512);
    chk("reen_leftSample", int'(leftSample), 480);
    chk("reen_rightSample", int'(rightSample), 480);

    // Disable on the very edge where the counter wraps.
    repeat (511) @(negedge clk);
    apuEnable = 1'b0;
    @(negedge clk);
    chk("wrapdis_strobe", int'(sampleStrobe), 0);
    chk("wrapdis_leftSample", int'(leftSample), 0);
    chk("wrapdis_rightSample", int'(rightSample), 0);
    apuEnable = 1'b1;

    // Asynchronous reset mid-frame while PWM is high.
    wait_strobe(n);
    chk("rst2_strobe_cycles", n, 512);
    repeat (100) @(negedge clk);
    chk("rst2_leftPwm_before", int'(leftPwm), 1);
    #2 rstN = 1'b0;
    #1;
    chk("rst2_leftPwm", int'(leftPwm), 0);
    chk("rst2_rightPwm", int'(rightPwm), 0);
    chk("rst2_leftSample", int'(leftSample), 0);
    chk("rst2_rightSample", int'(rightSample), 0);
    @(negedge clk);
    rstN = 1'b1;
    wait_strobe(n);
    chk("rst2_restart_cycles", n, 512);
    chk("rst2_leftSample_after", int'(leftSample), 480);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
